// File: rtl/down_counter.sv
// Loadable down counter with wrap, saturate or auto-reload on underflow.
// zero is decoded straight from the count register; borrow is a registered one-cycle pulse.
module down_counter #(
   parameter int                 WIDTH   = 4,
   parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   input  logic             sat,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             borrow
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             borrow_q, borrow_d;
   logic             at_zero;

   assign at_zero = (count_q == '0);

   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      borrow_d = 1'b0;
      if (load) begin
         count_d  = load_val;
         reload_d = load_val;
      end else if (en) begin
         if (at_zero) begin
            // Underflow: auto_reload outranks sat; otherwise wrap to all ones.
            borrow_d = 1'b1;
            if (auto_reload)
               count_d = reload_q;
            else if (sat)
               count_d = '0;
            else
               count_d = {WIDTH{1'b1}};
         end else begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= RST_VAL;
         reload_q <= RST_VAL;
         borrow_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
         borrow_q <= borrow_d;
      end
   end

   assign count  = count_q;
   assign zero   = at_zero;
   assign borrow = borrow_q;

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001: Parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002: Parameter RST_VAL, default {WIDTH{1'b1}} (4'b1111), value loaded into count and reload register on reset.
REQ-003: clk  input  1  single clock; all state updates on posedge clk.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: en  input  1  count enable; when high, decrement by one per clock.
REQ-006: load  input  1  synchronous load of load_val into count and reload register.
REQ-007: load_val  input  WIDTH  value for load.
REQ-008: auto_reload  input  1  on underflow, reload from reload register instead of wrapping.
REQ-009: sat  input  1  on underflow, hold at zero; ignored when auto_reload=1.
REQ-010: count  output  WIDTH  current count value, registered.
REQ-011: zero  output  1  high whenever count==0, decoded from the count register with no added latency.
REQ-012: borrow  output  1  registered single-cycle pulse, high in the cycle after an underflow event.

Function
REQ-013: Priority per clock edge SHALL be load > en > hold.
REQ-014: load=1: count <= load_val, reload register <= load_val, borrow <= 0, regardless of en.
REQ-015: load=0, en=0: count and reload register hold; borrow <= 0.
REQ-016: load=0, en=1, count!=0: count <= count-1, borrow <= 0.
REQ-017: Underflow event is defined as load=0, en=1, count==0.
REQ-018: On underflow with auto_reload=1: count <= reload register value, borrow <= 1.
REQ-019: On underflow with auto_reload=0, sat=0: count <= {WIDTH{1'b1}} (modulo-2^WIDTH wrap), borrow <= 1.
REQ-020: On underflow with auto_reload=0, sat=1: count stays 0, borrow <= 1.
REQ-021: Arithmetic is unsigned WIDTH-bit; no intermediate result wider than WIDTH is visible on count.
REQ-022: Latency: count reflects load or decrement one clock after the sampling edge; zero follows count combinationally; borrow asserts on the same edge that performs the underflow update.
REQ-023: borrow SHALL NOT stay high for two consecutive cycles unless underflow occurs on consecutive edges (e.g. sat=1 with en held at count 0, or reload value 0 with auto_reload=1).
REQ-024: Reload register value 0 with auto_reload=1 is legal; the result is count=0 with borrow pulsing on every enabled edge.
REQ-025: Changes on auto_reload and sat take effect on the next edge only; no combinational path from them to count.
REQ-026: All flip-flops are clocked by clk only; no register is clocked by a count bit (no ripple clocking).

Reset
REQ-027: While rst=1, count = RST_VAL, reload register = RST_VAL, borrow = 0, immediately and independent of clk.
REQ-028: zero after reset SHALL equal (RST_VAL==0).
REQ-029: Assertion of rst mid-count or mid-borrow-pulse SHALL abort the operation; the first enabled edge after deassertion decrements from RST_VAL.
REQ-030: On the edge coincident with rst deassertion, no load or decrement SHALL be taken.

Verification
REQ-031: Reset, then en=1 for 17 clocks (WIDTH=4, auto_reload=0, sat=0) -> count 15,14..0,15,14; zero high only at 0; borrow one pulse on the 0->15 edge.
REQ-032: load=1, load_val=5, then en=1, auto_reload=1 for 7 clocks -> count 5,4,3,2,1,0,5; borrow pulses once with the 0->5 transition.
REQ-033: load_val=2, sat=1, auto_reload=0, en=1 for 5 clocks -> count 2,1,0,0,0; borrow high for each edge taken at count 0.
REQ-034: load=1 and en=1 together with load_val=9 at count=3 -> count=9 next cycle, no decrement, borrow=0.
REQ-035: rst pulsed asynchronously (between edges) at count=6 with borrow high -> count=15 and borrow=0 without a clock edge; counting resumes 15,14 after release.
REQ-036: auto_reload=1, load_val=0, en=1 for 3 clocks -> count stays 0, zero=1, borrow high on all 3 edges.
